if_prefetch_buffer: RTL

- Instruction-fetch front end that produces the 32-bit instruction word and its PC for the ID-stage decoder.
- Issues word fetches to instruction memory over a request/grant/rvalid interface.
- Buffers returned words in an in-order FIFO and hands them to ID with a valid/ready handshake.
- Handles PC redirects (branch/jump/trap) by flushing the FIFO and discarding in-flight responses.

---
 rtl/if_prefetch_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: instruction fetch front end with request issue, PC pairing queue and in-order prefetch FIFO
module if_prefetch_buffer #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o,
    input  logic        instr_ready_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned QW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned DW = 8;

    typedef enum logic {RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc;
    logic [OW-1:0]   outst;
    logic [DW-1:0]   discard;
    logic [31:0]     pcq [MAX_OUTSTANDING];
    logic [QW-1:0]   pcq_wr, pcq_rd;
    logic [64:0]     fifo [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic            gnt_ok, resp_ok, push, pop;

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    // A request only issues when every granted word is guaranteed a free FIFO slot
    assign imem_req_o    = ~rst_i & ~redirect_i & (state_q == RUN)
                         & (32'(cnt) + 32'(outst) < DEPTH) & (32'(outst) < MAX_OUTSTANDING);
    assign imem_addr_o   = fetch_pc;
    assign gnt_ok        = imem_req_o & imem_gnt_i;
    // Responses with nothing in flight (e.g. after reset) are ignored entirely
    assign resp_ok       = imem_rvalid_i & ((discard != '0) | (outst != '0));
    assign push          = resp_ok & ~redirect_i & (discard == '0);
    assign instr_valid_o = (cnt != '0) & ~redirect_i;
    assign pop           = instr_valid_o & instr_ready_i;
    assign instr_o       = fifo[rd_ptr][31:0];
    assign instr_pc_o    = fifo[rd_ptr][63:32];
    assign instr_fault_o = instr_valid_o & fifo[rd_ptr][64];

    // Fetch state register
    always_ff @(posedge clk_i) state_q <= rst_i ? RUN : state_d;

    // Halt once a faulting word is buffered; only a redirect resumes fetching
    always_comb begin
        state_d = redirect_i ? RUN : (push & imem_err_i) ? HALT : state_q;
    end

    // Fetch PC, in-flight accounting and PC queue pairing grants with responses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
            outst    <= '0;
            discard  <= discard + DW'(outst) - DW'(resp_ok);
            pcq_wr   <= '0;
            pcq_rd   <= '0;
        end else begin
            if (gnt_ok) begin
                fetch_pc    <= fetch_pc + 32'd4;
                pcq[pcq_wr] <= fetch_pc;
                pcq_wr      <= qinc(pcq_wr);
            end
            if (push)
                pcq_rd <= qinc(pcq_rd);
            if (resp_ok & (discard != '0))
                discard <= discard - 1'b1;
            outst <= outst + OW'(gnt_ok) - OW'(push);
        end
    end

    // In-order instruction FIFO of {fault, pc, word}; flushed by redirect
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo   <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (redirect_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= {imem_err_i, pcq[pcq_rd], imem_rdata_i};
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule
